// File: rtl/bwm_pkg.sv
// Shared types and helpers for the Baugh-Wooley multiply-accumulate slice.
// Latency: n/a (package: parameters, FSM encoding, saturating-add helper).
// Backpressure: n/a.
package bwm_pkg;

  localparam int ACC_W_DEF   = 16;
  localparam int N_TERMS_DEF = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  // Adds an 8-bit signed product to an accumulator that is acc_w bits wide
  // (carried sign-extended in 32 bits). The sum is formed exactly; overflow
  // means it does not fit in acc_w signed bits, which is the same as the top
  // two bits of an (acc_w+1)-bit sum differing. Returns {ovf, result}. Only
  // the low acc_w bits of the result are meaningful: either the clamped value
  // or the plain low bits (two's-complement wrap).
  function automatic logic [32:0] sat_add(input logic signed [31:0] acc,
                                          input logic signed [7:0]  p,
                                          input int                 acc_w,
                                          input logic               sat_en);
    longint     sum;
    longint     maxv;
    longint     minv;
    logic       ovf;
    logic [31:0] res;
    sum  = longint'(acc) + longint'(p);
    maxv = (longint'(1) << (acc_w - 1)) - 1;
    minv = -(longint'(1) << (acc_w - 1));
    ovf  = (sum > maxv) || (sum < minv);
    if (ovf && sat_en) begin
      res = (sum < 0) ? 32'(minv) : 32'(maxv);
    end else begin
      res = 32'(sum);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/bwm_4bit.sv
// Signed 4x4 Baugh-Wooley multiplier, 8-bit signed product.
// Latency: 0 (purely combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b = signed 4-bit operands; p = signed 8-bit product.
module bwm_4bit (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  output logic signed [7:0] p
);

  always_comb begin
    logic [7:0] s;
    logic       t;
    // Baugh-Wooley correction constant: 2^(2n-1) + 2^n for n = 4.
    s = 8'b1001_0000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        t = a[i] & b[j];
        s = s + ({7'b0, t} << (i + j));
      end
    end
    // Partial products involving exactly one sign bit enter inverted.
    for (int i = 0; i < 3; i++) begin
      t = ~(a[i] & b[3]);
      s = s + ({7'b0, t} << (i + 3));
    end
    for (int j = 0; j < 3; j++) begin
      t = ~(a[3] & b[j]);
      s = s + ({7'b0, t} << (j + 3));
    end
    t = a[3] & b[3];
    s = s + ({7'b0, t} << 6);
    p = signed'(s);
  end

endmodule

// File: rtl/bwm_mac_acc.sv
// Signed 4x4 multiply-accumulate: one ACC_W-bit dot product per N_TERMS pairs.
// Latency: last accept edge -> out_valid at the following edge; 1 pair/cycle.
// Backpressure: in_ready drops once N_TERMS issued and while a result waits.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b operand
//   handshake; acc_clear synchronous frame abort; out_valid/out_ready/out_acc/
//   out_ovf result handshake (out_ovf sticky per frame); busy frame in flight.
module bwm_mac_acc
  import bwm_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       in_a,
  input  logic signed [3:0]       in_b,
  input  logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam logic [7:0] NT = 8'(N_TERMS);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [3:0]       op_a;
  logic signed [3:0]       op_b;
  logic                    op_vld;
  logic signed [7:0]       prod;
  logic signed [ACC_W-1:0] acc;
  logic                    ovf_sticky;
  logic [7:0]              issued;
  logic [7:0]              retired;

  logic                    accept;
  logic                    final_term;
  logic                    handshake;
  logic                    sa_ovf;
  logic [31:0]             sa_res;
  logic signed [ACC_W-1:0] acc_sum;

  bwm_4bit u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  assign accept     = in_valid & in_ready;
  assign final_term = op_vld & (retired == NT - 8'd1);
  assign handshake  = out_valid & out_ready;

  assign {sa_ovf, sa_res} = sat_add(32'(acc), prod, ACC_W, SAT_EN);
  assign acc_sum          = signed'(sa_res[ACC_W-1:0]);

  // Bits above ACC_W in the helper's result carry no information.
  generate
    if (ACC_W < 32) begin : g_hi
      logic unused_sa_hi;
      assign unused_sa_hi = ^sa_res[31:ACC_W];
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (acc_clear) begin
      state_nxt = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (final_term) state_nxt = DONE;
        DONE:    if (handshake)  state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  // in_ready deliberately ignores in_valid so the upstream sees no comb loop.
  always_comb begin
    in_ready = (state == COLLECT) && (issued < NT) && !acc_clear;
    busy     = (issued != 8'd0) || (state == DONE);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_vld     <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      issued     <= '0;
      retired    <= '0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (acc_clear) begin
      // Abort drops any in-flight term and any result still waiting.
      op_vld     <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      issued     <= '0;
      retired    <= '0;
      out_valid  <= 1'b0;
    end else begin
      // A new accept at the retire edge keeps op_vld high: full throughput.
      op_vld <= accept;
      if (accept) begin
        op_a   <= in_a;
        op_b   <= in_b;
        issued <= issued + 8'd1;
      end

      // Handshake only happens in DONE, where nothing is accepted or retired.
      if (handshake) begin
        out_valid  <= 1'b0;
        acc        <= '0;
        ovf_sticky <= 1'b0;
        issued     <= '0;
        retired    <= '0;
      end else if (op_vld) begin
        acc        <= acc_sum;
        ovf_sticky <= ovf_sticky | sa_ovf;
        retired    <= retired + 8'd1;
        if (final_term) begin
          out_acc   <= acc_sum;
          out_ovf   <= ovf_sticky | sa_ovf;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bwm_mac_acc.sv
module tb_bwm_mac_acc;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [3:0] in_a;
  logic signed [3:0] in_b;
  logic              acc_clear;
  logic              out_ready;

  logic               def_in_ready, def_out_valid, def_out_ovf, def_busy;
  logic signed [15:0] def_out_acc;
  logic               s8_in_ready, s8_out_valid, s8_out_ovf, s8_busy;
  logic signed [7:0]  s8_out_acc;
  logic               w8_in_ready, w8_out_valid, w8_out_ovf, w8_busy;
  logic signed [7:0]  w8_out_acc;
  logic               n1_in_ready, n1_out_valid, n1_out_ovf, n1_busy;
  logic signed [15:0] n1_out_acc;

  int n_chk  = 0;
  int n_pass = 0;

  bwm_mac_acc u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(def_in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear),
    .out_valid(def_out_valid), .out_ready(out_ready),
    .out_acc(def_out_acc), .out_ovf(def_out_ovf), .busy(def_busy)
  );

  bwm_mac_acc #(.ACC_W(8), .N_TERMS(4), .SAT_EN(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s8_in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear),
    .out_valid(s8_out_valid), .out_ready(out_ready),
    .out_acc(s8_out_acc), .out_ovf(s8_out_ovf), .busy(s8_busy)
  );

  bwm_mac_acc #(.ACC_W(8), .N_TERMS(4), .SAT_EN(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w8_in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear),
    .out_valid(w8_out_valid), .out_ready(out_ready),
    .out_acc(w8_out_acc), .out_ovf(w8_out_ovf), .busy(w8_busy)
  );

  bwm_mac_acc #(.ACC_W(16), .N_TERMS(1), .SAT_EN(1'b1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n1_in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear),
    .out_valid(n1_out_valid), .out_ready(out_ready),
    .out_acc(n1_out_acc), .out_ovf(n1_out_ovf), .busy(n1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b);
    in_valid = v;
    in_a     = 4'(a);
    in_b     = 4'(b);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    acc_clear = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", def_out_valid, 0);
    chk("rst_out_acc",   def_out_acc,   0);
    chk("rst_out_ovf",   def_out_ovf,   0);
    chk("rst_busy",      def_busy,      0);
    #20 rst = 1'b0;
    tick();

    // Mixed-sign frame: 6 - 56 + 64 + 49 = 63.
    drive(1, 3, 2);
    chk("t1_in_ready_idle", def_in_ready, 1);
    tick();
    chk("t1_busy_after_accept", def_busy, 1);
    drive(1, -8, 7);  tick();
    drive(1, -8, -8); tick();
    drive(1, 7, 7);   tick();
    drive(0, 0, 0);
    chk("t1_in_ready_full", def_in_ready, 0);
    chk("t1_no_early_valid", def_out_valid, 0);
    tick();
    chk("t1_out_valid", def_out_valid, 1);
    chk("t1_out_acc",   def_out_acc,   63);
    chk("t1_out_ovf",   def_out_ovf,   0);
    chk("t1_in_ready_done", def_in_ready, 0);
    tick();
    chk("t1_valid_dropped", def_out_valid, 0);
    chk("t1_in_ready_back", def_in_ready, 1);
    chk("t1_busy_idle",     def_busy,     0);

    // Four 64s: 8-bit sat clamps to 127, 8-bit wrap ends at 0, 16-bit = 256.
    for (int i = 0; i < 4; i++) begin
      drive(1, -8, -8);
      tick();
    end
    drive(0, 0, 0);
    tick();
    chk("t2_s8_valid", s8_out_valid, 1);
    chk("t2_s8_acc",   s8_out_acc,   127);
    chk("t2_s8_ovf",   s8_out_ovf,   1);
    chk("t2_w8_acc",   w8_out_acc,   0);
    chk("t2_w8_ovf",   w8_out_ovf,   1);
    chk("t2_def_acc",  def_out_acc,  256);
    chk("t2_def_ovf",  def_out_ovf,  0);
    tick();

    // Result held under backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1);
      tick();
    end
    drive(0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1);
      chk($sformatf("t3_hold_valid_%0d", i), def_out_valid, 1);
      chk($sformatf("t3_hold_acc_%0d", i),   def_out_acc,   4);
      chk($sformatf("t3_hold_rdy_%0d", i),   def_in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    drive(0, 0, 0);
    chk("t3_acc_at_hs", def_out_acc, 4);
    tick();
    chk("t3_valid_after_hs", def_out_valid, 0);
    chk("t3_rdy_after_hs",   def_in_ready,  1);

    // Abort after two terms; the pair offered with acc_clear is dropped.
    drive(1, 7, 7); tick();
    drive(1, 7, 7); tick();
    chk("t4_busy_mid", def_busy, 1);
    acc_clear = 1'b1;
    drive(1, 7, 7);
    chk("t4_rdy_clear", def_in_ready, 0);
    tick();
    acc_clear = 1'b0;
    drive(0, 0, 0);
    chk("t4_busy_cleared", def_busy, 0);
    chk("t4_no_valid",     def_out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 3);
      tick();
    end
    drive(0, 0, 0);
    tick();
    chk("t4_valid", def_out_valid, 1);
    chk("t4_acc",   def_out_acc,   24);
    chk("t4_ovf",   def_out_ovf,   0);
    tick();

    // Async reset in the middle of a frame.
    drive(1, 4, 4); tick();
    drive(1, 4, 4); tick();
    drive(1, 4, 4); tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", def_out_valid, 0);
    chk("t5_rst_acc",   def_out_acc,   0);
    chk("t5_rst_ovf",   def_out_ovf,   0);
    chk("t5_rst_busy",  def_busy,      0);
    chk("t5_rst_n1_acc", n1_out_acc,   0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, -1, 1);
      tick();
    end
    drive(0, 0, 0);
    tick();
    chk("t5_valid", def_out_valid, 1);
    chk("t5_acc",   def_out_acc,   -4);
    chk("t5_s8_acc", s8_out_acc,   -4);
    tick();
    tick();
    tick();

    // Gapped input: 4 x (5 * -3) = -60.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5, -3);
      tick();
      chk($sformatf("t6_opvld_set_%0d", i), u_def.op_vld, 1);
      drive(0, 0, 0);
      if (i < 3) begin
        tick();
        chk($sformatf("t6_opvld_gap_%0d", i), u_def.op_vld, 0);
        if (i == 0) begin
          chk("t6_n1_valid", n1_out_valid, 1);
          chk("t6_n1_acc",   n1_out_acc,   -15);
        end
      end
    end
    chk("t6_no_early_valid", def_out_valid, 0);
    tick();
    chk("t6_valid", def_out_valid, 1);
    chk("t6_acc",   def_out_acc,   -60);
    chk("t6_ovf",   def_out_ovf,   0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
